// File: rtl/fridge_temp_ctrl.sv
// Refrigerator thermostat: polls a 12-bit SPI ADC, runs a hysteresis compressor loop, raises alarms
// and scans a 4-digit 7-segment display. Defining DEFROST_EN adds a periodic defrost heater timer.
module fridge_temp_ctrl #(
  parameter int          SAMPLE_CYCLES     = 100000,
  parameter int          SPI_DIV           = 5,
  parameter int          DEBOUNCE_CYCLES   = 20000,
  parameter int          DOOR_ALARM_CYCLES = 1200000000,
  parameter int          HYST              = 10,
  parameter int          HIGH_ALARM        = 50,
  parameter int          DIGIT_CYCLES      = 10000,
  parameter logic [31:0] DEFROST_PERIOD    = 32'hFFFF_FFFF,
  parameter logic [31:0] DEFROST_LEN       = 32'd100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adc_miso,
  output logic       adc_mosi,
  output logic       adc_sclk,
  output logic       adc_cs_n,
  output logic       compressor_pwm,
  output logic       alarm,
  input  logic       door_sensor,
  input  logic       button_up,
  input  logic       button_down,
  input  logic       button_mode,
  output logic [6:0] seven_seg,
  output logic [3:0] digit_sel,
  output logic [3:0] status_led,
  output logic       defrost_heater
);
  localparam int SW  = $clog2(SAMPLE_CYCLES + 1);
  localparam int DW  = $clog2(SPI_DIV + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW  = $clog2(DIGIT_CYCLES + 1);
  localparam logic signed [11:0] HYST_S = 12'(HYST);
  localparam logic signed [11:0] HIGH_S = 12'(HIGH_ALARM);

  typedef enum logic {SPI_IDLE, SPI_BUSY} spi_state_t;

  // sync bit order: {miso, door, mode, down, up}
  logic [4:0] sync1, sync2;
  logic       miso_s, door_s;
  logic [2:0] btn_deb, btn_rise;
  logic [DBW-1:0] deb_cnt [3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {adc_miso, door_sensor, button_mode, button_down, button_up};
      sync2 <= sync1;
    end
  end
  assign miso_s = sync2[4];
  assign door_s = sync2[3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_deb  <= '0;
      btn_rise <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        btn_rise[i] <= 1'b0;
        if (sync2[i] == btn_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          btn_deb[i]  <= sync2[i];
          btn_rise[i] <= sync2[i];
          deb_cnt[i]  <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [SW-1:0] smp_cnt;
  logic          smp_tick;
  assign smp_tick = (smp_cnt == SW'(SAMPLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) smp_cnt <= '0;
    else        smp_cnt <= smp_tick ? '0 : smp_cnt + 1'b1;
  end

  // half counts SCLK half-periods: even -> rising edge (sample), odd -> falling edge, 32 -> cs_n release
  spi_state_t    spi_state;
  logic [DW-1:0] div_cnt;
  logic [5:0]    half;
  logic [14:0]   sr;
  logic [11:0]   code;
  logic          valid, code_upd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spi_state <= SPI_IDLE;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b0;
      adc_mosi  <= 1'b0;
      div_cnt   <= '0;
      half      <= '0;
      sr        <= '0;
      code      <= '0;
      valid     <= 1'b0;
      code_upd  <= 1'b0;
    end else begin
      code_upd <= 1'b0;
      case (spi_state)
        SPI_IDLE: if (smp_tick) begin
          spi_state <= SPI_BUSY;
          adc_cs_n  <= 1'b0;
          adc_mosi  <= 1'b1;
          div_cnt   <= '0;
          half      <= '0;
        end
        default: if (div_cnt == DW'(SPI_DIV - 1)) begin
          div_cnt <= '0;
          half    <= half + 6'd1;
          if (half == 6'd32) begin
            adc_cs_n  <= 1'b1;
            code      <= sr[14:3];
            valid     <= 1'b1;
            code_upd  <= 1'b1;
            spi_state <= SPI_IDLE;
          end else begin
            adc_sclk <= ~half[0];
            if (!half[0]) sr <= {sr[13:0], miso_s};
            else          adc_mosi <= 1'b0;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      endcase
    end
  end

  logic [21:0]        scaled;
  logic signed [11:0] temp_t;
  logic               fault;
  logic               unused_bits;
  assign scaled      = 22'(code) * 22'd1000;
  assign temp_t      = $signed({2'b00, scaled[21:12]}) - 12'sd500;
  assign fault       = (code == 12'd0) || (code == 12'hFFF);
  assign unused_bits = ^{sr[2:0], scaled[11:0]};

`ifdef DEFROST_EN
  logic [31:0] dfr_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dfr_cnt        <= '0;
      defrost_heater <= 1'b0;
    end else begin
      dfr_cnt        <= (dfr_cnt == DEFROST_PERIOD - 32'd1) ? '0 : dfr_cnt + 32'd1;
      defrost_heater <= (dfr_cnt < DEFROST_LEN);
    end
  end
`else
  logic unused_defrost;
  assign unused_defrost = ^{DEFROST_PERIOD, DEFROST_LEN};
  assign defrost_heater = 1'b0;
`endif

  logic [31:0]        door_cnt;
  logic               door_alarm;
  logic signed [11:0] sp;
  logic               show_sp, high_alarm, fault_r;
  assign door_alarm = door_s && (door_cnt >= 32'(DOOR_ALARM_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      door_cnt       <= '0;
      sp             <= 12'sd40;
      show_sp        <= 1'b0;
      high_alarm     <= 1'b0;
      fault_r        <= 1'b0;
      compressor_pwm <= 1'b0;
      alarm          <= 1'b0;
    end else begin
      if (!door_s)                          door_cnt <= '0;
      else if (door_cnt != 32'hFFFF_FFFF)   door_cnt <= door_cnt + 32'd1;
      if (btn_rise[0] && !btn_rise[1])      sp <= (sp >= 12'sd90)   ? 12'sd100  : sp + 12'sd10;
      else if (btn_rise[1] && !btn_rise[0]) sp <= (sp <= -12'sd190) ? -12'sd200 : sp - 12'sd10;
      if (btn_rise[2]) show_sp <= ~show_sp;
      if (code_upd) begin
        fault_r    <= fault;
        high_alarm <= (temp_t >= sp + HIGH_S);
      end
      if (defrost_heater) compressor_pwm <= 1'b0;
      else if (code_upd) begin
        if (fault)                        compressor_pwm <= 1'b0;
        else if (temp_t >= sp + HYST_S)   compressor_pwm <= 1'b1;
        else if (temp_t <= sp - HYST_S)   compressor_pwm <= 1'b0;
      end
      alarm <= door_alarm | high_alarm | (valid & fault_r);
    end
  end

  assign status_led = {defrost_heater, alarm, door_s, compressor_pwm};

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;  4'd3: return 7'h4F;
      4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;  4'd7: return 7'h07;
      4'd8: return 7'h7F;  4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  // signed division truncates toward zero, which is the display rounding we want
  logic signed [11:0] disp_val, whole;
  logic               disp_neg, dash_all, dig_tick;
  logic [11:0]        mag;
  logic [3:0]         tens, units, next_sel;
  logic [6:0]         next_seg;
  logic [CW-1:0]      dig_cnt;
  assign disp_val = show_sp ? sp : temp_t;
  assign whole    = disp_val / 12'sd10;
  assign disp_neg = (whole < 12'sd0);
  assign mag      = disp_neg ? 12'(-whole) : 12'(whole);
  assign tens     = 4'(mag / 12'd10);
  assign units    = 4'(mag % 12'd10);
  assign dash_all = !show_sp && !valid;
  assign dig_tick = (dig_cnt == CW'(DIGIT_CYCLES - 1));
  assign next_sel = dig_tick ? {digit_sel[0], digit_sel[3:1]} : digit_sel;

  always_comb begin
    next_seg = 7'h00;
    if (dash_all) next_seg = 7'h40;
    else begin
      case (next_sel)
        4'b1000: next_seg = disp_neg ? 7'h40 : 7'h00;
        4'b0100: next_seg = (tens == 4'd0) ? 7'h00 : seg7(tens);
        4'b0010: next_seg = seg7(units);
        4'b0001: next_seg = show_sp ? 7'h6D : 7'h77;
        default: next_seg = 7'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_cnt   <= '0;
      digit_sel <= 4'b1000;
      seven_seg <= 7'h00;
    end else begin
      dig_cnt   <= dig_tick ? '0 : dig_cnt + 1'b1;
      digit_sel <= next_sel;
      seven_seg <= next_seg;
    end
  end
endmodule

// File: tb/tb_fridge_temp_ctrl.sv
// Bench for fridge_temp_ctrl: ADC model feeding chosen/random codes, thermostat model checked per sample.
module tb_fridge_temp_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, adc_miso = 1'b0, door_sensor = 1'b0;
  logic button_up = 1'b0, button_down = 1'b0, button_mode = 1'b0;
  logic adc_mosi, adc_sclk, adc_cs_n, compressor_pwm, alarm, defrost_heater;
  logic [6:0] seven_seg;
  logic [3:0] digit_sel, status_led;

  fridge_temp_ctrl #(
    .SAMPLE_CYCLES(200), .SPI_DIV(5), .DEBOUNCE_CYCLES(50), .DOOR_ALARM_CYCLES(5000),
    .HYST(10), .HIGH_ALARM(50), .DIGIT_CYCLES(20),
    .DEFROST_PERIOD(32'd1000), .DEFROST_LEN(32'd100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_miso(adc_miso), .adc_mosi(adc_mosi), .adc_sclk(adc_sclk),
    .adc_cs_n(adc_cs_n), .compressor_pwm(compressor_pwm), .alarm(alarm), .door_sensor(door_sensor),
    .button_up(button_up), .button_down(button_down), .button_mode(button_mode),
    .seven_seg(seven_seg), .digit_sel(digit_sel), .status_led(status_led), .defrost_heater(defrost_heater)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // ADC model: 16-bit word {0, code, 000} shifted MSB first, next bit presented after each SCLK fall
  logic [11:0] cur_code = 12'd2375;
  logic        stuck = 1'b0;
  logic [15:0] word = 16'h0, mosi_seen = 16'h0;
  int          bit_idx = 0, sclk_rises = 0;

  always @(negedge adc_cs_n) begin
    word = stuck ? 16'hFFFF : {1'b0, cur_code, 3'b000};
    bit_idx = 15; adc_miso = word[15]; mosi_seen = 16'h0; sclk_rises = 0;
  end
  always @(posedge adc_sclk) begin
    mosi_seen = {mosi_seen[14:0], adc_mosi}; sclk_rises++;
  end
  always @(negedge adc_sclk) if (adc_cs_n === 1'b0 && bit_idx > 0) begin
    bit_idx--; adc_miso = word[bit_idx];
  end

  // thermostat reference model
  int   sp_m = 40, temp_m = 0;
  logic comp_m = 1'b0, high_m = 1'b0, fault_m = 1'b0, valid_m = 1'b0, show_sp_m = 1'b0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int temp_of(input int c);
    return (c * 1000) / 4096 - 500;
  endfunction

  function automatic logic [27:0] disp_m(input int v, input logic sp_mode, input logic vld);
    int w, m;
    logic [6:0] d3, d2, d1, d0;
    if (!sp_mode && !vld) return {4{7'h40}};
    w  = v / 10;
    m  = (w < 0) ? -w : w;
    d3 = (w < 0) ? 7'h40 : 7'h00;
    d2 = (m / 10 == 0) ? 7'h00 : seg_tab[m / 10];
    d1 = seg_tab[m % 10];
    d0 = sp_mode ? 7'h6D : 7'h77;
    return {d3, d2, d1, d0};
  endfunction

  task automatic wait_frame_end();
    int n = 0;
    while (adc_cs_n !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    while (adc_cs_n !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    total++;
    if (n >= 1000) begin bad++; $display("FAIL frame_timeout: waited %0d cycles, required < 1000", n); end
  endtask

  task automatic do_sample(input int c);
    int t;
    wait_frame_end();
    stuck = (c == 4095); cur_code = 12'(c);
    wait_frame_end();
    repeat (4) @(negedge clk);
    t = temp_of(c);
    valid_m = 1'b1; temp_m = t;
    fault_m = (c == 0) || (c == 4095);
    high_m  = (t >= sp_m + 50);
    if (fault_m)             comp_m = 1'b0;
    else if (t >= sp_m + 10) comp_m = 1'b1;
    else if (t <= sp_m - 10) comp_m = 1'b0;
  endtask

  task automatic read_display(output logic [27:0] d);
    d = '0;
    for (int k = 3; k >= 0; k--) begin
      int n = 0;
      logic [3:0] want;
      want = 4'b0001 << k;
      while (digit_sel !== want && n < 200) begin @(negedge clk); n++; end
      @(negedge clk);
      if (n >= 200) d[k*7 +: 7] = 7'bx;
      else          d[k*7 +: 7] = seven_seg;
    end
  endtask

  task automatic press(input logic up, input logic dn, input logic md);
    button_up = up; button_down = dn; button_mode = md;
    repeat (80) @(negedge clk);
    button_up = 1'b0; button_down = 1'b0; button_mode = 1'b0;
    repeat (80) @(negedge clk);
    if (up && !dn) sp_m = (sp_m + 10 > 100) ? 100 : sp_m + 10;
    if (dn && !up) sp_m = (sp_m - 10 < -200) ? -200 : sp_m - 10;
    if (md) show_sp_m = ~show_sp_m;
  endtask

  task automatic test_reset();
    logic [27:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({adc_cs_n, adc_sclk, adc_mosi, compressor_pwm, alarm, defrost_heater, status_led, digit_sel, seven_seg}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1000, 7'h00}) begin
      bad++;
      $display("FAIL reset_outputs: cs=%b sclk=%b mosi=%b comp=%b alarm=%b heat=%b led=%b sel=%b seg=%h",
               adc_cs_n, adc_sclk, adc_mosi, compressor_pwm, alarm, defrost_heater, status_led, digit_sel, seven_seg);
    end
    rst_n = 1'b1;
    sp_m = 40; show_sp_m = 1'b0; valid_m = 1'b0; comp_m = 1'b0; high_m = 1'b0; fault_m = 1'b0;
    read_display(d);
    total++;
    if (d !== disp_m(0, 1'b0, 1'b0)) begin bad++; $display("FAIL reset_display: got %h want %h", d, disp_m(0, 1'b0, 1'b0)); end
  endtask

  task automatic test_compressor();
    logic [27:0] d;
    int c;
    do_sample(2375);
    total++;
    if (sclk_rises !== 16 || mosi_seen !== 16'h8000) begin
      bad++; $display("FAIL spi_frame: rises=%0d mosi=%h want 16 / 8000", sclk_rises, mosi_seen);
    end
    do_sample(2375);
    total++;
    if (compressor_pwm !== 1'b1 || alarm !== 1'b0) begin
      bad++; $display("FAIL comp_8C: comp=%b alarm=%b want 1/0", compressor_pwm, alarm);
    end
    do_sample(2130);
    total++;
    if (compressor_pwm !== 1'b0) begin bad++; $display("FAIL comp_2C: comp=%b want 0", compressor_pwm); end
    do_sample(2375);
    do_sample(2212);
    total++;
    if (compressor_pwm !== 1'b1) begin bad++; $display("FAIL comp_hold_4C: comp=%b want 1", compressor_pwm); end
    repeat (8) begin
      c = int'($urandom_range(2600, 2000));
      do_sample(c);
      total++;
      if (compressor_pwm !== comp_m || alarm !== high_m) begin
        bad++; $display("FAIL comp_random code=%0d: comp=%b alarm=%b want %b/%b", c, compressor_pwm, alarm, comp_m, high_m);
      end
    end
    do_sample(1900);
    read_display(d);
    total++;
    if (d !== disp_m(temp_m, 1'b0, 1'b1)) begin bad++; $display("FAIL display_negative: got %h want %h", d, disp_m(temp_m, 1'b0, 1'b1)); end
  endtask

  task automatic test_setpoint();
    logic [27:0] d;
    press(1'b0, 1'b0, 1'b1);
    read_display(d);
    total++;
    if (d !== disp_m(sp_m, 1'b1, 1'b1)) begin bad++; $display("FAIL sp_40: got %h want %h", d, disp_m(sp_m, 1'b1, 1'b1)); end
    press(1'b1, 1'b0, 1'b0);
    read_display(d);
    total++;
    if (d !== {7'h00, 7'h00, 7'h6D, 7'h6D}) begin bad++; $display("FAIL sp_50: got %h want %h", d, {7'h00, 7'h00, 7'h6D, 7'h6D}); end
    repeat (2) press(1'b0, 1'b1, 1'b0);
    read_display(d);
    total++;
    if (d !== disp_m(sp_m, 1'b1, 1'b1)) begin bad++; $display("FAIL sp_30: got %h want %h", d, disp_m(sp_m, 1'b1, 1'b1)); end
    press(1'b1, 1'b1, 1'b0);
    read_display(d);
    total++;
    if (d !== disp_m(sp_m, 1'b1, 1'b1)) begin bad++; $display("FAIL sp_both: got %h want %h", d, disp_m(sp_m, 1'b1, 1'b1)); end
    repeat (9) press(1'b1, 1'b0, 1'b0);
    read_display(d);
    total++;
    if (d !== disp_m(100, 1'b1, 1'b1)) begin bad++; $display("FAIL sp_max: got %h want %h", d, disp_m(100, 1'b1, 1'b1)); end
    repeat (31) press(1'b0, 1'b1, 1'b0);
    read_display(d);
    total++;
    if (d !== disp_m(-200, 1'b1, 1'b1)) begin bad++; $display("FAIL sp_min: got %h want %h", d, disp_m(-200, 1'b1, 1'b1)); end
    repeat (23) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    read_display(d);
    total++;
    if (d !== disp_m(temp_m, 1'b0, 1'b1)) begin bad++; $display("FAIL mode_back: got %h want %h", d, disp_m(temp_m, 1'b0, 1'b1)); end
  endtask

  task automatic test_door();
    do_sample(2212);
    total++;
    if (alarm !== high_m) begin bad++; $display("FAIL door_pre: alarm=%b want %b", alarm, high_m); end
    door_sensor = 1'b1;
    repeat (4990) @(negedge clk);
    total++;
    if (alarm !== 1'b0) begin bad++; $display("FAIL door_early: alarm=%b want 0", alarm); end
    repeat (14) @(negedge clk);
    total++;
    if (alarm !== 1'b1 || status_led[1] !== 1'b1) begin
      bad++; $display("FAIL door_alarm: alarm=%b led1=%b want 1/1", alarm, status_led[1]);
    end
    door_sensor = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (alarm !== 1'b0 || status_led[1] !== 1'b0) begin
      bad++; $display("FAIL door_close: alarm=%b led1=%b want 0/0", alarm, status_led[1]);
    end
  endtask

  task automatic test_high_alarm();
    do_sample(2662);
    total++;
    if (alarm !== 1'b1 || compressor_pwm !== comp_m || high_m !== 1'b1) begin
      bad++; $display("FAIL high_15C: alarm=%b comp=%b want 1/%b", alarm, compressor_pwm, comp_m);
    end
    do_sample(2212);
    total++;
    if (alarm !== 1'b0 || compressor_pwm !== comp_m) begin
      bad++; $display("FAIL high_clear: alarm=%b comp=%b want 0/%b", alarm, compressor_pwm, comp_m);
    end
  endtask

  task automatic test_fault_and_reset();
    logic [27:0] d;
    int n = 0;
    do_sample(4095);
    total++;
    if (alarm !== 1'b1 || compressor_pwm !== 1'b0) begin
      bad++; $display("FAIL fault: alarm=%b comp=%b want 1/0", alarm, compressor_pwm);
    end
    while (adc_cs_n !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({adc_cs_n, adc_sclk, adc_mosi, compressor_pwm, alarm, defrost_heater, status_led, digit_sel, seven_seg}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b1000, 7'h00}) begin
      bad++;
      $display("FAIL midframe_reset: cs=%b sclk=%b mosi=%b comp=%b alarm=%b led=%b sel=%b seg=%h",
               adc_cs_n, adc_sclk, adc_mosi, compressor_pwm, alarm, status_led, digit_sel, seven_seg);
    end
    stuck = 1'b0;
    rst_n = 1'b1;
    sp_m = 40; show_sp_m = 1'b0; valid_m = 1'b0; comp_m = 1'b0; high_m = 1'b0; fault_m = 1'b0;
    read_display(d);
    total++;
    if (d !== {4{7'h40}}) begin bad++; $display("FAIL reset_dashes: got %h want %h", d, {4{7'h40}}); end
    do_sample(2375);
    total++;
    if (compressor_pwm !== 1'b1 || alarm !== 1'b0) begin
      bad++; $display("FAIL after_reset: comp=%b alarm=%b want 1/0", compressor_pwm, alarm);
    end
  endtask

`ifdef DEFROST_EN
  task automatic test_defrost();
    int bad_h = 0, bad_c = 0, on_seen = 0;
    logic exp_h;
    stuck = 1'b0; cur_code = 12'd2662;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 2500; k++) begin
      @(negedge clk);
      exp_h = ((k - 1) % 1000) < 100;
      if (defrost_heater !== exp_h || status_led[3] !== exp_h) bad_h++;
      if (exp_h && compressor_pwm !== 1'b0) bad_c++;
      if (!exp_h && compressor_pwm === 1'b1) on_seen++;
    end
    total++;
    if (bad_h != 0) begin bad++; $display("FAIL defrost_window: %0d wrong cycles, want 0", bad_h); end
    total++;
    if (bad_c != 0) begin bad++; $display("FAIL defrost_comp_off: %0d cycles compressor on, want 0", bad_c); end
    total++;
    if (on_seen == 0) begin bad++; $display("FAIL defrost_comp_resume: compressor never on, want on between defrosts"); end
  endtask
`else
  task automatic test_no_defrost();
    int hits = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (defrost_heater !== 1'b0 || status_led[3] !== 1'b0) hits++;
    end
    total++;
    if (hits != 0) begin bad++; $display("FAIL no_defrost: heater high %0d cycles, want 0", hits); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DEFROST_EN
    test_defrost();
`else
    test_compressor();
    test_setpoint();
    test_door();
    test_high_alarm();
    test_fault_and_reset();
    test_no_defrost();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
